// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: word size, canonical NOP, reset vector and
// the {instruction, pc} record carried through the fetch buffer.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Instruction fetches are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instruction, pc} records. Clear wins over
// push; the head entry is read straight out of the storage array.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t    mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            push_ok, pop_ok;

    assign pop_ok  = pop && (count_reg != '0) && !clear;
    assign push_ok = push && !clear && ((count_reg != FULL) || pop_ok);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
            count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: an entry is only observed once count covers it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_entry;
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word requests,
// buffers in-order responses for decode and squashes stale ones after redirects.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid_if,
    input  logic            imem_req_ready_if,
    output logic [XLEN-1:0] imem_req_addr_if,
    input  logic            imem_rsp_valid_if,
    input  logic [XLEN-1:0] imem_rsp_data_if,
    input  logic            redirect_valid_if,
    input  logic [XLEN-1:0] redirect_pc_if,
    output logic [XLEN-1:0] instruction_if,
    output logic [XLEN-1:0] pc_if,
    output logic [XLEN-1:0] pc_plus4_if,
    output logic            valid_if,
    input  logic            ready_id
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0]     CREDIT_LIMIT = CW1'(DEPTH);
    localparam logic [XLEN-1:0] START_PC     = word_align(RESET_PC);

    logic [XLEN-1:0] req_pc_reg, req_pc_next;
    logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_reg, drop_next;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_target;
    fetch_entry_t    head, push_entry;
    logic            pop, push, rsp_accept, req_fire;

    assign redirect_target = word_align(redirect_pc_if);
    assign valid_if        = (count != '0);
    assign pop             = valid_if && ready_id && !redirect_valid_if;

    // Slots already spoken for: requests in flight plus buffered words,
    // minus the one decode is taking this cycle.
    assign credit_used       = {1'b0, outstanding_reg} + {1'b0, count} - CW1'(pop);
    assign imem_req_valid_if = !redirect_valid_if && (credit_used < CREDIT_LIMIT);
    assign imem_req_addr_if  = req_pc_reg;
    assign req_fire          = imem_req_valid_if && imem_req_ready_if;

    // A response with nothing outstanding is a memory protocol error; ignore it.
    assign rsp_accept = imem_rsp_valid_if && (outstanding_reg != '0);
    assign push       = rsp_accept && (drop_reg == '0) && !redirect_valid_if;
    assign push_entry = '{instr: imem_rsp_data_if, pc: rsp_pc_reg};

    always_comb begin
        req_pc_next      = req_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        drop_next        = drop_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
        if (redirect_valid_if) begin
            req_pc_next = redirect_target;
            rsp_pc_next = redirect_target;
            // Everything still in flight belongs to the old path.
            drop_next   = outstanding_reg - CW'(rsp_accept);
        end else begin
            if (req_fire) req_pc_next = req_pc_reg + 32'd4;
            if (rsp_accept) begin
                if (drop_reg != '0) drop_next   = drop_reg - CW'(1);
                else                rsp_pc_next = rsp_pc_reg + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_pc_reg      <= START_PC;
            rsp_pc_reg      <= START_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            req_pc_reg      <= req_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (redirect_valid_if),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign instruction_if = valid_if ? head.instr : NOP_INSTR;
    assign pc_if          = valid_if ? head.pc : '0;
    assign pc_plus4_if    = pc_if + 32'd4;

endmodule
